// File: rtl/mult_pkg.sv
// Shared types and defaults for the sequential shift-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/twos_abs.sv
// Magnitude of a WIDTH-bit operand; sign_o flags a negative two's-complement input.
module twos_abs #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] val_i,
  input  logic             signed_i,
  output logic [WIDTH-1:0] mag_o,
  output logic             sign_o
);

  // The most negative value maps onto itself, which reads correctly as its unsigned magnitude.
  assign sign_o = signed_i & val_i[WIDTH-1];
  assign mag_o  = sign_o ? (~val_i + WIDTH'(1)) : val_i;

endmodule

// File: rtl/seq_mult.sv
// Sequential shift-add multiplier: one multiplier bit per clock, signed or unsigned operands,
// start/done handshake, result held until the next accepted start.
module seq_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int AW = 2 * WIDTH + 1;

  state_e             state_q;
  logic [AW-1:0]      acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mplier_q;
  logic [CW-1:0]      cnt_q;
  logic               neg_q, busy_q, done_q;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH:0]     upper_sum;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               a_neg, b_neg;

  twos_abs #(.WIDTH(WIDTH)) u_abs_a (
    .val_i    (a),
    .signed_i (signed_mode),
    .mag_o    (a_mag),
    .sign_o   (a_neg)
  );

  twos_abs #(.WIDTH(WIDTH)) u_abs_b (
    .val_i    (b),
    .signed_i (signed_mode),
    .mag_o    (b_mag),
    .sign_o   (b_neg)
  );

  // Partial product lands in the upper WIDTH+1 bits so the carry survives the right shift.
  always_comb begin
    upper_sum = acc_q[AW-1:WIDTH] + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    acc_d     = {upper_sum, acc_q[WIDTH-1:0]} >> 1;
    prod_d    = neg_q ? (~acc_d[2*WIDTH-1:0] + (2*WIDTH)'(1)) : acc_d[2*WIDTH-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      prod_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            mcand_q  <= a_mag;
            mplier_q <= b_mag;
            neg_q    <= a_neg ^ b_neg;
            acc_q    <= '0;
            cnt_q    <= CW'(WIDTH);
            busy_q   <= 1'b1;
            state_q  <= CALC;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        CALC: begin
          acc_q    <= acc_d;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            prod_q  <= prod_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign prod = prod_q;

endmodule

// File: tb/tb_seq_mult.sv
// Randomised and directed bench for seq_mult at WIDTH=4 and WIDTH=8 against an arithmetic model.
module tb_seq_mult;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start4, start8, smode;
  logic [7:0]  a_in, b_in;
  logic        busy4, done4, busy8, done8;
  logic [7:0]  prod4;
  logic [15:0] prod8;
  int          n_checks = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  seq_mult #(.WIDTH(4)) u_dut4 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start4),
    .signed_mode (smode),
    .a           (a_in[3:0]),
    .b           (b_in[3:0]),
    .busy        (busy4),
    .done        (done4),
    .prod        (prod4)
  );

  seq_mult #(.WIDTH(8)) u_dut8 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start8),
    .signed_mode (smode),
    .a           (a_in),
    .b           (b_in),
    .busy        (busy8),
    .done        (done8),
    .prod        (prod8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Exact product of two w-bit operands, wrapped to 2*w bits.
  function automatic logic [15:0] ref_mul(input int w, input logic [7:0] a, input logic [7:0] b,
                                          input logic s);
    longint m, x, y, p;
    m = (longint'(1) << w) - 1;
    x = longint'(a) & m;
    y = longint'(b) & m;
    if (s && x >= (longint'(1) << (w - 1))) x = x - (longint'(1) << w);
    if (s && y >= (longint'(1) << (w - 1))) y = y - (longint'(1) << w);
    p = x * y;
    return 16'(p & ((longint'(1) << (2 * w)) - 1));
  endfunction

  function automatic logic [15:0] prod_of(input int w);
    return (w == 4) ? {8'h00, prod4} : prod8;
  endfunction

  function automatic logic busy_of(input int w);
    return (w == 4) ? busy4 : busy8;
  endfunction

  function automatic logic done_of(input int w);
    return (w == 4) ? done4 : done8;
  endfunction

  task automatic set_start(input int w, input logic v);
    if (w == 4) start4 = v;
    else start8 = v;
  endtask

  task automatic launch(input int w, input logic [7:0] a, input logic [7:0] b, input logic s);
    a_in  = a;
    b_in  = b;
    smode = s;
    set_start(w, 1'b1);
  endtask

  // Called at the falling edge right after launch(); returns at the falling edge of the done cycle.
  // Operand inputs are scrambled during the computation; inject_k re-pulses start mid-flight.
  task automatic finish_op(input int w, input logic [15:0] exp, input int inject_k, input string tag);
    logic [15:0] prev;
    logic [31:0] tv;
    int          holds;
    prev  = prod_of(w);
    tv    = '0;
    holds = 0;
    for (int k = 1; k <= w + 1; k++) begin
      @(negedge clk);
      tv[k-1]      = busy_of(w);
      tv[16 + k-1] = done_of(w);
      if (k <= w) begin
        if (prod_of(w) !== prev) holds++;
        set_start(w, k == inject_k);
        a_in  = 8'($urandom);
        b_in  = 8'($urandom);
        smode = 1'($urandom);
      end else begin
        set_start(w, 1'b0);
      end
    end
    check({tag, " timing"}, tv, ((32'd1 << w) - 32'd1) | (32'd1 << (16 + w)));
    check({tag, " hold"}, holds, 0);
    check({tag, " prod"}, 32'(prod_of(w)), 32'(exp));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] ra, rb;
    logic       rs;
    int         dones;

    rst_n  = 1'b0;
    start4 = 1'b0;
    start8 = 1'b0;
    smode  = 1'b0;
    a_in   = '0;
    b_in   = '0;
    repeat (2) @(negedge clk);
    check("reset w4", 32'({busy4, done4, prod4}), 0);
    check("reset w8", 32'({busy8, done8, prod8}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases, back to back within each width.
    launch(4, 8'h0D, 8'h09, 1'b0); finish_op(4, 16'h0075, 0, "u4 13*9");
    launch(4, 8'h0D, 8'h09, 1'b1); finish_op(4, 16'h0015, 0, "s4 -3*-7");
    launch(4, 8'h07, 8'h08, 1'b1); finish_op(4, 16'h00C8, 0, "s4 7*-8");
    launch(8, 8'hFF, 8'hFF, 1'b0); finish_op(8, 16'hFE01, 0, "u8 ff*ff");
    launch(8, 8'h80, 8'h80, 1'b1); finish_op(8, 16'h4000, 0, "s8 80*80");
    launch(8, 8'hFF, 8'h7F, 1'b1); finish_op(8, 16'hFF81, 0, "s8 ff*7f");
    launch(8, 8'h00, 8'h80, 1'b1); finish_op(8, 16'h0000, 0, "s8 0*80");

    // Start re-pulsed with new operands mid-computation must be ignored.
    launch(8, 8'h9C, 8'h35, 1'b0);
    finish_op(8, ref_mul(8, 8'h9C, 8'h35, 1'b0), 3, "inject");
    @(negedge clk);
    check("inject ignored", 32'({busy8, done8}), 0);

    // Exhaustive WIDTH=4 sweep, each start issued in the done cycle of the previous one.
    launch(4, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 512; i++) begin
      int j;
      finish_op(4, ref_mul(4, 8'(i[7:4]), 8'(i[3:0]), i[8]), 0,
                $sformatf("sweep s%0d %0d*%0d", i[8], i[7:4], i[3:0]));
      j = i + 1;
      if (i < 511) launch(4, 8'(j[7:4]), 8'(j[3:0]), j[8]);
    end

    // Random WIDTH=8 operations.
    for (int i = 0; i < 150; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 1'($urandom);
      launch(8, ra, rb, rs);
      finish_op(8, ref_mul(8, ra, rb, rs), 0, $sformatf("rand s%0d %h*%h", rs, ra, rb));
    end

    // Reset during the third CALC cycle clears everything immediately and suppresses done.
    launch(8, 8'hFF, 8'hFF, 1'b0); finish_op(8, 16'hFE01, 0, "pre-reset");
    launch(8, 8'hB7, 8'h5A, 1'b0);
    repeat (3) @(negedge clk);
    set_start(8, 1'b0);
    #1 rst_n = 1'b0;
    #1 check("mid reset", 32'({busy8, done8, prod8}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) dones++;
    end
    check("no done after reset", dones, 0);
    launch(8, 8'h85, 8'h13, 1'b1);
    finish_op(8, ref_mul(8, 8'h85, 8'h13, 1'b1), 0, "post-reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
